// File: rtl/btn_event.sv
// btn_event: converts a conditioned button level into press / release / auto-repeat
// events, delivered through a single-entry valid/ready slot with a sticky overflow flag.
module btn_event #(
  parameter int SyncStages   = 2,
  parameter int HoldDelay    = 500,
  parameter int RepeatPeriod = 100,
  parameter int Inverted     = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sigin,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic       pressed,
  output logic       overflow,
  input  logic       ovf_clear
);

  localparam logic Inv      = (Inverted != 0);
  localparam logic RepeatEn = (RepeatPeriod != 0);
  localparam int   MaxCnt   = (HoldDelay > RepeatPeriod) ? HoldDelay : RepeatPeriod;
  localparam int   CntW     = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HoldDelay - 1);
  localparam logic [CntW-1:0] RepLoad  = CntW'((RepeatPeriod > 0) ? RepeatPeriod - 1 : 0);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, DOWN} state_e;
  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_e;

  logic [SyncStages-1:0] sync;
  logic                  level;
  logic                  rise;
  state_e                state, state_n;
  logic [CntW-1:0]       cnt, cnt_n;
  logic                  gen_valid;
  ev_e                   gen_code;
  logic                  xfer;
  logic                  slot_valid_n;
  ev_e                   slot_code, slot_code_n;
  logic                  ovf_set;

  // Chain resets to the inactive level so no spurious press follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= {SyncStages{Inv}};
    else       sync <= {sync[SyncStages-2:0], sigin};
  end

  assign level = sync[SyncStages-1] ^ Inv;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pressed <= 1'b0;
    else       pressed <= level;
  end

  assign rise = level & ~pressed;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          if (RepeatEn) begin
            state_n = HOLD;
            cnt_n   = HoldLoad;
          end else begin
            state_n = DOWN;
          end
        end
      end
      HOLD, REPEAT: begin
        if (!level) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = REPEAT;
          cnt_n   = RepLoad;
        end else begin
          cnt_n = cnt - CntW'(1);
        end
      end
      DOWN: begin
        if (!level) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Release is tested before counter expiry so it wins a same-cycle tie.
  always_comb begin
    gen_valid = 1'b0;
    gen_code  = EV_NONE;
    case (state)
      IDLE: begin
        if (rise) begin
          gen_valid = 1'b1;
          gen_code  = EV_PRESS;
        end
      end
      HOLD, REPEAT: begin
        if (!level) begin
          gen_valid = 1'b1;
          gen_code  = EV_RELEASE;
        end else if (cnt == '0) begin
          gen_valid = 1'b1;
          gen_code  = EV_REPEAT;
        end
      end
      DOWN: begin
        if (!level) begin
          gen_valid = 1'b1;
          gen_code  = EV_RELEASE;
        end
      end
      default: gen_valid = 1'b0;
    endcase
  end

  assign xfer = ev_valid & ev_ready;

  // A full, stalled slot drops new events, except that a release may replace a pending repeat.
  always_comb begin
    slot_valid_n = ev_valid;
    slot_code_n  = slot_code;
    ovf_set      = 1'b0;
    if (xfer) begin
      slot_valid_n = 1'b0;
      slot_code_n  = EV_NONE;
    end
    if (gen_valid) begin
      if (!ev_valid || xfer) begin
        slot_valid_n = 1'b1;
        slot_code_n  = gen_code;
      end else begin
        ovf_set = 1'b1;
        if (gen_code == EV_RELEASE && slot_code == EV_REPEAT) slot_code_n = EV_RELEASE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ev_valid  <= 1'b0;
      slot_code <= EV_NONE;
      overflow  <= 1'b0;
    end else begin
      ev_valid  <= slot_valid_n;
      slot_code <= slot_code_n;
      overflow  <= ovf_set | (overflow & ~ovf_clear);
    end
  end

  assign ev_code = slot_code;

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: three parameterisations checked every cycle against an
// event-timing model, plus directed scenarios with hand-computed expectations.
module tb_btn_event;

  logic       clock = 1'b0;
  logic       rst [3];
  logic       sig [3];
  logic       rdy [3];
  logic       clr [3];
  logic       vld [3];
  logic [1:0] code [3];
  logic       prs [3];
  logic       ovf [3];

  int checks = 0;
  int errors = 0;
  int np = 0, nr = 0, nq = 0;

  always #5 clock = ~clock;

  btn_event #(.SyncStages(2), .HoldDelay(8), .RepeatPeriod(4), .Inverted(0)) u0 (
    .clock(clock), .reset(rst[0]), .sigin(sig[0]), .ev_valid(vld[0]), .ev_code(code[0]),
    .ev_ready(rdy[0]), .pressed(prs[0]), .overflow(ovf[0]), .ovf_clear(clr[0]));

  btn_event #(.SyncStages(2), .HoldDelay(8), .RepeatPeriod(4), .Inverted(1)) u1 (
    .clock(clock), .reset(rst[1]), .sigin(sig[1]), .ev_valid(vld[1]), .ev_code(code[1]),
    .ev_ready(rdy[1]), .pressed(prs[1]), .overflow(ovf[1]), .ovf_clear(clr[1]));

  btn_event #(.SyncStages(2), .HoldDelay(8), .RepeatPeriod(0), .Inverted(0)) u2 (
    .clock(clock), .reset(rst[2]), .sigin(sig[2]), .ev_valid(vld[2]), .ev_code(code[2]),
    .ev_ready(rdy[2]), .pressed(prs[2]), .overflow(ovf[2]), .ovf_clear(clr[2]));

  // Model configuration per instance
  bit inv_p [3] = '{1'b0, 1'b1, 1'b0};
  int hd_p  [3] = '{8, 8, 8};
  int rp_p  [3] = '{4, 4, 0};

  // Model state: raw input history, button-down flag, press time, slot and flag
  bit       ms1 [3];
  bit       ms2 [3];
  bit       mplv [3];
  bit       mdown [3];
  bit       mv [3];
  bit       mo [3];
  logic [1:0] mc [3];
  int       kk [3];
  int       tp [3];

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s u%0d t=%0t got=%0h want=%0h", nm, inst, $time, got, want);
    end
  endtask

  task automatic chk_ev(input string nm, input int i, input logic v, input logic [1:0] c);
    chk({nm, ".valid"}, i, {31'd0, vld[i]}, {31'd0, v});
    chk({nm, ".code"}, i, {30'd0, code[i]}, {30'd0, c});
  endtask

  // Event = function of the level two samples back; repeats fall at
  // press+HoldDelay+n*RepeatPeriod while still held.
  task automatic model_step(input int i);
    bit lvl;
    int gen;
    bit xfer;
    bit ovs;
    if (rst[i]) begin
      ms1[i] = inv_p[i]; ms2[i] = inv_p[i]; mplv[i] = 1'b0; mdown[i] = 1'b0;
      mv[i] = 1'b0; mc[i] = 2'b00; mo[i] = 1'b0; kk[i] = 0; tp[i] = 0;
      return;
    end
    kk[i]++;
    lvl = ms2[i] ^ inv_p[i];
    gen = 0;
    if (!mdown[i] && lvl && !mplv[i]) begin
      gen = 1; mdown[i] = 1'b1; tp[i] = kk[i];
    end else if (mdown[i] && !lvl) begin
      gen = 2; mdown[i] = 1'b0;
    end else if (mdown[i] && rp_p[i] != 0 && (kk[i] - tp[i]) >= hd_p[i] &&
                 ((kk[i] - tp[i] - hd_p[i]) % rp_p[i]) == 0) begin
      gen = 3;
    end
    xfer = mv[i] && rdy[i];
    ovs  = 1'b0;
    if (gen != 0) begin
      if (!mv[i] || xfer) begin
        mv[i] = 1'b1; mc[i] = 2'(gen);
      end else begin
        ovs = 1'b1;
        if (gen == 2 && mc[i] == 2'b11) mc[i] = 2'b10;
      end
    end else if (xfer) begin
      mv[i] = 1'b0; mc[i] = 2'b00;
    end
    if (ovs) mo[i] = 1'b1;
    else if (clr[i]) mo[i] = 1'b0;
    mplv[i] = lvl;
    ms2[i]  = ms1[i];
    ms1[i]  = sig[i];
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        model_step(i);
        chk("cmp.valid", i, {31'd0, vld[i]}, {31'd0, mv[i]});
        chk("cmp.code", i, {30'd0, code[i]}, {30'd0, mc[i]});
        chk("cmp.pressed", i, {31'd0, prs[i]}, {31'd0, mplv[i]});
        chk("cmp.overflow", i, {31'd0, ovf[i]}, {31'd0, mo[i]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; rdy[i] = 1'b1; clr[i] = 1'b0; sig[i] = 1'b0;
    end
    sig[1] = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk_ev("reset", i, 1'b0, 2'b00);
      chk("reset.pressed", i, {31'd0, prs[i]}, 32'd0);
      chk("reset.overflow", i, {31'd0, ovf[i]}, 32'd0);
    end
    rst[0] = 1'b0;
    rst[2] = 1'b0;
    repeat (5) @(negedge clock);

    // Short tap: press then release, no repeat
    sig[0] = 1'b1;
    for (int e = 10; e <= 20; e++) begin
      @(negedge clock);
      chk_ev("t1", 0, (e == 12 || e == 15), (e == 12) ? 2'b01 : (e == 15) ? 2'b10 : 2'b00);
      chk("t1.pressed", 0, {31'd0, prs[0]}, {31'd0, (e >= 12 && e <= 14)});
      if (e == 12) sig[0] = 1'b0;
    end

    // Long hold with repeats
    sig[0] = 1'b1;
    for (int e = 10; e <= 40; e++) begin
      @(negedge clock);
      chk_ev("t2", 0, (e == 12 || e == 20 || e == 24 || e == 28 || e == 32 || e == 33),
             (e == 12) ? 2'b01 : (e == 33) ? 2'b10 :
             (e == 20 || e == 24 || e == 28 || e == 32) ? 2'b11 : 2'b00);
      chk("t2.pressed", 0, {31'd0, prs[0]}, {31'd0, (e >= 12 && e <= 32)});
      if (e == 30) sig[0] = 1'b0;
    end
    chk("t2.overflow", 0, {31'd0, ovf[0]}, 32'd0);

    // Stalled consumer: press held, repeats and release dropped
    rdy[0] = 1'b0;
    sig[0] = 1'b1;
    for (int e = 10; e <= 40; e++) begin
      @(negedge clock);
      chk_ev("t3", 0, (e >= 12 && e <= 36), (e >= 12 && e <= 36) ? 2'b01 : 2'b00);
      chk("t3.overflow", 0, {31'd0, ovf[0]}, {31'd0, (e >= 20 && e <= 33)});
      chk("t3.pressed", 0, {31'd0, prs[0]}, {31'd0, (e >= 12 && e <= 31)});
      if (e == 29) sig[0] = 1'b0;
      if (e == 33) clr[0] = 1'b1;
      if (e == 34) clr[0] = 1'b0;
      if (e == 36) rdy[0] = 1'b1;
    end

    // Release overwrites a pending repeat; clear loses to a coincident overflow
    sig[0] = 1'b1;
    for (int e = 10; e <= 34; e++) begin
      @(negedge clock);
      chk_ev("t3b", 0, (e == 12) || (e >= 20 && e <= 28),
             (e == 12) ? 2'b01 : (e >= 20 && e <= 26) ? 2'b11 : (e >= 27 && e <= 28) ? 2'b10 : 2'b00);
      chk("t3b.overflow", 0, {31'd0, ovf[0]}, {31'd0, (e >= 24 && e <= 29)});
      chk("t3b.pressed", 0, {31'd0, prs[0]}, {31'd0, (e >= 12 && e <= 26)});
      if (e == 14) rdy[0] = 1'b0;
      if (e == 24) sig[0] = 1'b0;
      if (e == 26) clr[0] = 1'b1;
      if (e == 27) clr[0] = 1'b0;
      if (e == 28) rdy[0] = 1'b1;
      if (e == 29) clr[0] = 1'b1;
      if (e == 30) clr[0] = 1'b0;
    end

    // Reset while repeating with the button still held
    sig[0] = 1'b1;
    for (int e = 10; e <= 24; e++) @(negedge clock);
    chk_ev("t5.pre", 0, 1'b1, 2'b11);
    rst[0] = 1'b1;
    #1;
    chk_ev("t5.rst", 0, 1'b0, 2'b00);
    chk("t5.rst.pressed", 0, {31'd0, prs[0]}, 32'd0);
    chk("t5.rst.overflow", 0, {31'd0, ovf[0]}, 32'd0);
    @(negedge clock);
    rst[0] = 1'b0;
    for (int e = 26; e <= 30; e++) begin
      @(negedge clock);
      chk_ev("t5", 0, (e == 28), (e == 28) ? 2'b01 : 2'b00);
      chk("t5.pressed", 0, {31'd0, prs[0]}, {31'd0, (e >= 28)});
    end
    sig[0] = 1'b0;
    repeat (6) @(negedge clock);

    // Active-low input, reset released with input inactive
    rst[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clock);
      chk_ev("t4", 1, (e == 7), (e == 7) ? 2'b01 : 2'b00);
      chk("t4.pressed", 1, {31'd0, prs[1]}, {31'd0, (e >= 7)});
      if (e == 4) sig[1] = 1'b0;
    end
    sig[1] = 1'b1;
    repeat (6) @(negedge clock);

    // Repeat disabled: one press and one release over a long hold
    sig[2] = 1'b1;
    for (int e = 10; e <= 70; e++) begin
      @(negedge clock);
      if (vld[2]) begin
        if (code[2] == 2'b01) np++;
        else if (code[2] == 2'b10) nr++;
        else nq++;
      end
      if (e == 12) chk_ev("t6.press", 2, 1'b1, 2'b01);
      if (e == 62) chk_ev("t6.release", 2, 1'b1, 2'b10);
      if (e == 59) sig[2] = 1'b0;
    end
    chk("t6.presses", 2, np, 1);
    chk("t6.releases", 2, nr, 1);
    chk("t6.others", 2, nq, 0);

    // Press/release one cycle apart stream back-to-back
    sig[2] = 1'b1;
    @(negedge clock);
    sig[2] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk_ev("t6.pair1", 2, 1'b1, 2'b01);
    chk("t6.pair1.pressed", 2, {31'd0, prs[2]}, 32'd1);
    @(negedge clock);
    chk_ev("t6.pair2", 2, 1'b1, 2'b10);
    chk("t6.pair2.pressed", 2, {31'd0, prs[2]}, 32'd0);
    @(negedge clock);
    chk_ev("t6.pair3", 2, 1'b0, 2'b00);
    chk("t6.overflow", 2, {31'd0, ovf[2]}, 32'd0);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
